// File: rtl/cpu_master_wrapper.sv
// Single-beat AXI master that bridges a simple stall/done CPU port onto AR/R/AW/W/B.
// One transaction at a time; requests are accepted only in IDLE.
module cpu_master_wrapper #(
   parameter logic [3:0] MASTER_ID = 4'd0
) (
   input  logic        ACLK,
   input  logic        ARESETn,

   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [3:0]  cpu_strb,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_stall,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,

   output logic [3:0]  M_ARID,
   output logic [31:0] M_ARAddr,
   output logic [3:0]  M_ARLen,
   output logic [2:0]  M_ARSize,
   output logic [1:0]  M_ARBurst,
   output logic        M_ARValid,
   input  logic        M_ARReady,

   input  logic [3:0]  M_RID,
   input  logic [31:0] M_RData,
   input  logic [1:0]  M_RResp,
   input  logic        M_RLast,
   input  logic        M_RValid,
   output logic        M_RReady,

   output logic [3:0]  M_AWID,
   output logic [31:0] M_AWAddr,
   output logic [3:0]  M_AWLen,
   output logic [2:0]  M_AWSize,
   output logic [1:0]  M_AWBurst,
   output logic        M_AWValid,
   input  logic        M_AWReady,

   output logic [31:0] M_WData,
   output logic [3:0]  M_WStrb,
   output logic        M_WLast,
   output logic        M_WValid,
   input  logic        M_WReady,

   input  logic [3:0]  M_BID,
   input  logic [1:0]  M_BResp,
   input  logic        M_BValid,
   output logic        M_BReady
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  strb_q;
   logic        aw_done_q;
   logic        w_done_q;

   logic        ar_hs;
   logic        r_hs;
   logic        aw_hs;
   logic        w_hs;
   logic        b_hs;

   // IDs, RLast and BID are deliberately ignored
   logic        unused_inputs;
   assign unused_inputs = ^{M_RID, M_BID, M_RLast};

   assign ar_hs = M_ARValid & M_ARReady;
   assign r_hs  = M_RValid  & M_RReady;
   assign aw_hs = M_AWValid & M_AWReady;
   assign w_hs  = M_WValid  & M_WReady;
   assign b_hs  = M_BValid  & M_BReady;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               state_nxt = cpu_we ? WR_REQ : RD_ADDR;
            end
         end
         RD_ADDR: begin
            if (ar_hs) begin
               state_nxt = RD_DATA;
            end
         end
         RD_DATA: begin
            if (r_hs) begin
               state_nxt = IDLE;
            end
         end
         WR_REQ: begin
            // AW and W complete independently, possibly in the same cycle
            if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
               state_nxt = WR_RESP;
            end
         end
         WR_RESP: begin
            if (b_hs) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Valids/readies decode straight from state so reset clears them without a clock
   always_comb begin
      M_ARValid = 1'b0;
      M_RReady  = 1'b0;
      M_AWValid = 1'b0;
      M_WValid  = 1'b0;
      M_BReady  = 1'b0;
      case (state)
         RD_ADDR: M_ARValid = 1'b1;
         RD_DATA: M_RReady  = 1'b1;
         WR_REQ: begin
            M_AWValid = ~aw_done_q;
            M_WValid  = ~w_done_q;
         end
         WR_RESP: M_BReady  = 1'b1;
         default: ;
      endcase
   end

   assign cpu_stall = (state != IDLE) | cpu_req;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         cpu_done  <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         cpu_done <= r_hs | b_hs;
         cpu_err  <= (r_hs & (M_RResp != 2'b00)) | (b_hs & (M_BResp != 2'b00));
         if (r_hs) begin
            cpu_rdata <= M_RData;
         end
         if ((state == IDLE) && cpu_req) begin
            addr_q    <= cpu_addr;
            wdata_q   <= cpu_wdata;
            strb_q    <= cpu_strb;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end else if (state == WR_REQ) begin
            if (aw_hs) begin
               aw_done_q <= 1'b1;
            end
            if (w_hs) begin
               w_done_q <= 1'b1;
            end
         end
      end
   end

   assign M_ARID    = MASTER_ID;
   assign M_ARAddr  = addr_q;
   assign M_ARLen   = 4'd0;
   assign M_ARSize  = 3'b010;
   assign M_ARBurst = 2'b01;

   assign M_AWID    = MASTER_ID;
   assign M_AWAddr  = addr_q;
   assign M_AWLen   = 4'd0;
   assign M_AWSize  = 3'b010;
   assign M_AWBurst = 2'b01;

   assign M_WData   = wdata_q;
   assign M_WStrb   = strb_q;
   assign M_WLast   = 1'b1;

endmodule

// File: tb/tb_cpu_master_wrapper.sv
// Bench for cpu_master_wrapper: delay-programmable AXI slave plus a transaction-level model.
module tb_cpu_master_wrapper;

   localparam logic [3:0] MID = 4'hA;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        cpu_req, cpu_we;
   logic [3:0]  cpu_strb;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_stall, cpu_done, cpu_err;
   logic [31:0] cpu_rdata;
   logic [3:0]  M_ARID, M_ARLen, M_AWID, M_AWLen;
   logic [31:0] M_ARAddr, M_AWAddr, M_WData;
   logic [2:0]  M_ARSize, M_AWSize;
   logic [1:0]  M_ARBurst, M_AWBurst;
   logic        M_ARValid, M_ARReady;
   logic [3:0]  M_RID, M_BID;
   logic [31:0] M_RData;
   logic [1:0]  M_RResp, M_BResp;
   logic        M_RLast, M_RValid, M_RReady;
   logic        M_AWValid, M_AWReady;
   logic [3:0]  M_WStrb;
   logic        M_WLast, M_WValid, M_WReady;
   logic        M_BValid, M_BReady;

   cpu_master_wrapper #(.MASTER_ID(MID)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_strb(cpu_strb), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_err(cpu_err),
      .cpu_rdata(cpu_rdata),
      .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen), .M_ARSize(M_ARSize),
      .M_ARBurst(M_ARBurst), .M_ARValid(M_ARValid), .M_ARReady(M_ARReady),
      .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast),
      .M_RValid(M_RValid), .M_RReady(M_RReady),
      .M_AWID(M_AWID), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen), .M_AWSize(M_AWSize),
      .M_AWBurst(M_AWBurst), .M_AWValid(M_AWValid), .M_AWReady(M_AWReady),
      .M_WData(M_WData), .M_WStrb(M_WStrb), .M_WLast(M_WLast), .M_WValid(M_WValid),
      .M_WReady(M_WReady),
      .M_BID(M_BID), .M_BResp(M_BResp), .M_BValid(M_BValid), .M_BReady(M_BReady)
   );

   initial forever #5 ACLK = ~ACLK;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   // slave configuration (written by stimulus)
   int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
   logic [31:0] r_data_cfg = '0;
   logic [1:0]  r_resp_cfg = '0, b_resp_cfg = '0;

   // handshakes seen in the cycle just ended (written by the compare process)
   bit s_ar_hs, s_r_hs, s_aw_hs, s_w_hs, s_b_hs;

   // transaction-level model
   bit          busy, m_we, m_ar_done, m_aw_done, m_w_done, exp_done, exp_err;
   logic [31:0] m_addr, m_wdata, exp_rdata;
   logic [3:0]  m_strb;
   int          ar_beats = 0;

   initial forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
         chkb("rst_arvalid", M_ARValid, 1'b0);
         chkb("rst_awvalid", M_AWValid, 1'b0);
         chkb("rst_wvalid",  M_WValid,  1'b0);
         chkb("rst_rready",  M_RReady,  1'b0);
         chkb("rst_bready",  M_BReady,  1'b0);
         chkb("rst_done",    cpu_done,  1'b0);
         chkb("rst_err",     cpu_err,   1'b0);
         chk ("rst_rdata",   cpu_rdata, 32'd0);
         busy = 0; exp_done = 0; exp_err = 0; exp_rdata = '0;
         m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
         s_ar_hs = 0; s_r_hs = 0; s_aw_hs = 0; s_w_hs = 0; s_b_hs = 0;
      end else begin
         chk("ar_id",    32'(M_ARID),    32'(MID));
         chk("aw_id",    32'(M_AWID),    32'(MID));
         chk("ar_len",   32'(M_ARLen),   32'd0);
         chk("aw_len",   32'(M_AWLen),   32'd0);
         chk("ar_size",  32'(M_ARSize),  32'd2);
         chk("aw_size",  32'(M_AWSize),  32'd2);
         chk("ar_burst", 32'(M_ARBurst), 32'd1);
         chk("aw_burst", 32'(M_AWBurst), 32'd1);
         chkb("w_last",  M_WLast, 1'b1);
         chkb("cpu_done", cpu_done, exp_done);
         chkb("cpu_err",  cpu_err,  exp_err);
         chk ("cpu_rdata", cpu_rdata, exp_rdata);
         chkb("cpu_stall", cpu_stall, busy | cpu_req);
         chkb("ar_valid", M_ARValid, busy & !m_we & !m_ar_done);
         chkb("r_ready",  M_RReady,  busy & !m_we & m_ar_done);
         chkb("aw_valid", M_AWValid, busy & m_we & !m_aw_done);
         chkb("w_valid",  M_WValid,  busy & m_we & !m_w_done);
         chkb("b_ready",  M_BReady,  busy & m_we & m_aw_done & m_w_done);
         if (M_ARValid) chk("ar_addr", M_ARAddr, m_addr);
         if (M_AWValid) chk("aw_addr", M_AWAddr, m_addr);
         if (M_WValid) begin
            chk("w_data", M_WData, m_wdata);
            chk("w_strb", 32'(M_WStrb), 32'(m_strb));
         end
         s_ar_hs = M_ARValid & M_ARReady;
         s_r_hs  = M_RValid  & M_RReady;
         s_aw_hs = M_AWValid & M_AWReady;
         s_w_hs  = M_WValid  & M_WReady;
         s_b_hs  = M_BValid  & M_BReady;
         if (s_ar_hs) ar_beats++;
         exp_done = s_r_hs | s_b_hs;
         exp_err  = (s_r_hs && M_RResp != 2'b00) || (s_b_hs && M_BResp != 2'b00);
         if (s_r_hs) exp_rdata = M_RData;
         if (s_ar_hs) m_ar_done = 1;
         if (s_aw_hs) m_aw_done = 1;
         if (s_w_hs)  m_w_done  = 1;
         if (busy) begin
            if (s_r_hs || s_b_hs) busy = 0;
         end else if (cpu_req) begin
            busy = 1; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata; m_strb = cpu_strb;
            m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
         end
      end
   end

   // AXI slave: each ready/valid rises a programmed number of cycles after it becomes eligible
   int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   bit rd_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;

   initial begin
      M_ARReady = 0; M_RValid = 0; M_AWReady = 0; M_WReady = 0; M_BValid = 0;
      M_RID = '0; M_BID = '0; M_RLast = 1'b1; M_RData = '0; M_RResp = '0; M_BResp = '0;
      forever begin
         @(posedge ACLK); #1;
         if (!ARESETn) begin
            rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            M_ARReady = 0; M_RValid = 0; M_AWReady = 0; M_WReady = 0; M_BValid = 0;
         end else begin
            if (s_ar_hs) begin rd_pend = 1; r_cnt = 0; end
            if (s_r_hs) rd_pend = 0;
            if (s_aw_hs) aw_got = 1;
            if (s_w_hs) w_got = 1;
            if (s_b_hs) b_pend = 0;
            if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
            if (M_ARValid) begin M_ARReady = (ar_cnt >= ar_delay); ar_cnt++; end
            else begin M_ARReady = 0; ar_cnt = 0; end
            if (M_AWValid) begin M_AWReady = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin M_AWReady = 0; aw_cnt = 0; end
            if (M_WValid) begin M_WReady = (w_cnt >= w_delay); w_cnt++; end
            else begin M_WReady = 0; w_cnt = 0; end
            if (rd_pend) begin M_RValid = (r_cnt >= r_delay); r_cnt++; end
            else M_RValid = 0;
            if (b_pend) begin M_BValid = (b_cnt >= b_delay); b_cnt++; end
            else M_BValid = 0;
            M_RData = r_data_cfg; M_RResp = r_resp_cfg; M_BResp = b_resp_cfg;
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      @(posedge ACLK); #1;
      cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_strb = s;
      @(posedge ACLK); #1;
      cpu_req = 0; cpu_we = ~we; cpu_addr = ~a; cpu_wdata = ~d; cpu_strb = ~s;
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      do begin
         @(negedge ACLK);
         n++;
      end while (!cpu_done && n < bound);
      if (!cpu_done) chkb("done_timeout", cpu_done, 1'b1);
   endtask

   initial begin
      int n;
      int b0;
      ARESETn = 0; cpu_req = 0; cpu_we = 0; cpu_strb = '0; cpu_addr = '0; cpu_wdata = '0;
      repeat (2) @(posedge ACLK);
      #3 ARESETn = 1;

      // read: ARReady immediate, RValid two cycles after the AR handshake
      ar_delay = 0; r_delay = 1; r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = 2'b00;
      b0 = ar_beats;
      issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
      wait_done(20, n);
      chk("rd_latency", 32'(n), 32'd4);
      chk("rd_data", cpu_rdata, 32'hDEAD_BEEF);
      chkb("rd_err", cpu_err, 1'b0);
      chk("rd_ar_beats", 32'(ar_beats - b0), 32'd1);
      @(negedge ACLK);
      chkb("rd_done_pulse", cpu_done, 1'b0);

      // write: W accepted in cycle 1, AW in cycle 3
      aw_delay = 2; w_delay = 0; b_delay = 0; b_resp_cfg = 2'b00;
      issue(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011);
      @(negedge ACLK);
      chkb("wr_c1_wvalid", M_WValid, 1'b1);
      chkb("wr_c1_awvalid", M_AWValid, 1'b1);
      @(negedge ACLK);
      chkb("wr_c2_wvalid", M_WValid, 1'b0);
      chkb("wr_c2_awvalid", M_AWValid, 1'b1);
      @(negedge ACLK);
      chkb("wr_c3_awvalid", M_AWValid, 1'b1);
      chkb("wr_c3_awready", M_AWReady, 1'b1);
      wait_done(20, n);
      chk("wr_latency", 32'(n), 32'd2);
      chk("wr_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
      chkb("wr_err", cpu_err, 1'b0);

      // AR backpressure for 10 cycles
      ar_delay = 10; r_delay = 0; r_data_cfg = 32'hCAFE_0001;
      issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK);
         chkb("bp_arvalid", M_ARValid, 1'b1);
         chk("bp_araddr", M_ARAddr, 32'h0000_0040);
         chkb("bp_stall", cpu_stall, 1'b1);
      end
      wait_done(20, n);
      chk("bp_latency", 32'(n), 32'd3);
      chk("bp_rdata", cpu_rdata, 32'hCAFE_0001);

      // write with SLVERR response
      aw_delay = 0; w_delay = 0; b_delay = 1; b_resp_cfg = 2'b10;
      issue(1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 4'hF);
      wait_done(20, n);
      chkb("err_done", cpu_done, 1'b1);
      chkb("err_err", cpu_err, 1'b1);
      @(negedge ACLK);
      chkb("err_done_clr", cpu_done, 1'b0);
      chkb("err_err_clr", cpu_err, 1'b0);
      b_resp_cfg = 2'b00;

      // read with DECERR: error flagged, data still captured
      ar_delay = 0; r_delay = 0; r_resp_cfg = 2'b11; r_data_cfg = 32'h0BAD_0BAD;
      issue(1'b0, 32'h0000_0044, 32'h0, 4'h0);
      wait_done(20, n);
      chkb("rderr_err", cpu_err, 1'b1);
      chk("rderr_rdata", cpu_rdata, 32'h0BAD_0BAD);
      r_resp_cfg = 2'b00;

      // cpu_req held with different contents while busy must be ignored
      ar_delay = 3; r_delay = 0; r_data_cfg = 32'h5555_AAAA;
      @(posedge ACLK); #1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0050;
      repeat (3) begin
         @(posedge ACLK); #1;
         cpu_we = 1; cpu_addr = 32'h0000_0060;
      end
      @(posedge ACLK); #1;
      cpu_req = 0;
      wait_done(20, n);
      chk("ign_rdata", cpu_rdata, 32'h5555_AAAA);

      // asynchronous reset while in RD_DATA
      ar_delay = 0; r_delay = 30; r_data_cfg = 32'h7777_7777;
      issue(1'b0, 32'h0000_0070, 32'h0, 4'h0);
      n = 0;
      while (!M_RReady && n < 5) begin @(negedge ACLK); n++; end
      chkb("rst_in_rd_data", M_RReady, 1'b1);
      @(posedge ACLK); #2;
      ARESETn = 0;
      #1;
      chkb("arst_arvalid", M_ARValid, 1'b0);
      chkb("arst_rready", M_RReady, 1'b0);
      chkb("arst_awvalid", M_AWValid, 1'b0);
      chkb("arst_wvalid", M_WValid, 1'b0);
      chkb("arst_bready", M_BReady, 1'b0);
      chkb("arst_stall", cpu_stall, 1'b0);
      chk("arst_rdata", cpu_rdata, 32'd0);
      @(posedge ACLK); #3;
      ARESETn = 1;

      aw_delay = 0; w_delay = 0; b_delay = 0;
      issue(1'b1, 32'h0000_0080, 32'h0BAD_F00D, 4'b1100);
      wait_done(20, n);
      chk("post_rst_wr_latency", 32'(n), 32'd3);
      r_delay = 0; r_data_cfg = 32'h1357_9BDF;
      issue(1'b0, 32'h0000_0084, 32'h0, 4'h0);
      wait_done(20, n);
      chk("post_rst_rd_latency", 32'(n), 32'd3);
      chk("post_rst_rdata", cpu_rdata, 32'h1357_9BDF);

      repeat (2) @(negedge ACLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cpu_master_wrapper.md
CPU_MASTER_WRAPPER -- requirements
Module: cpu_master_wrapper

Interface
REQ-001 SHALL have parameter MASTER_ID, default 4'd0: value driven on M_ARID and M_AWID.
REQ-002 SHALL have port ACLK  input  1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port ARESETn  input  1: asynchronous active-low reset.
REQ-004 SHALL have ports cpu_req  input  1 (access request pulse), cpu_we  input  1 (1 = write), cpu_strb  input  4 (active-high byte enables), cpu_addr  input  32, cpu_wdata  input  32.
REQ-005 SHALL have ports cpu_stall  output  1 (CPU hold), cpu_done  output  1 (completion pulse), cpu_err  output  1 (error response pulse), cpu_rdata  output  32 (read data).
REQ-006 SHALL have AXI AR ports M_ARID  output  4, M_ARAddr  output  32, M_ARLen  output  4, M_ARSize  output  3, M_ARBurst  output  2, M_ARValid  output  1, and M_ARReady  input  1.
REQ-007 SHALL have AXI R ports M_RID  input  4, M_RData  input  32, M_RResp  input  2, M_RLast  input  1, M_RValid  input  1, and M_RReady  output  1.
REQ-008 SHALL have AXI AW ports M_AWID  output  4, M_AWAddr  output  32, M_AWLen  output  4, M_AWSize  output  3, M_AWBurst  output  2, M_AWValid  output  1, and M_AWReady  input  1.
REQ-009 SHALL have AXI W and B ports M_WData  output  32, M_WStrb  output  4, M_WLast  output  1, M_WValid  output  1, M_WReady  input  1, M_BID  input  4, M_BResp  input  2, M_BValid  input  1, and M_BReady  output  1.

Function
REQ-010 SHALL issue only single-beat transfers: Len=0, Size=3'b010, Burst=2'b01 (INCR), WLast=1 on every beat, constant while not in reset.
REQ-011 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, and WR_RESP.
REQ-012 SHALL, in IDLE on cpu_req=1, register addr/wdata/strb and go to RD_ADDR if cpu_we=0 or WR_REQ if cpu_we=1; AXI valids rise on the following cycle.
REQ-013 SHALL ignore cpu_req in every state other than IDLE.
REQ-014 SHALL drive cpu_stall = (state != IDLE) | (state == IDLE & cpu_req).
REQ-015 SHALL, in RD_ADDR, hold M_ARValid=1 with stable M_ARAddr until the M_ARReady handshake, then go to RD_DATA.
REQ-016 SHALL, in RD_DATA, drive M_RReady=1; on the M_RValid handshake, register M_RData into cpu_rdata and go to IDLE.
REQ-017 SHALL, in WR_REQ, assert M_AWValid and M_WValid together; each SHALL drop independently after its own handshake, including the same-cycle case.
REQ-018 SHALL leave WR_REQ for WR_RESP only once both the AW and W handshakes have completed.
REQ-019 SHALL, in WR_RESP, drive M_BReady=1; on the M_BValid handshake, go to IDLE.
REQ-020 SHALL pulse cpu_done for exactly one cycle, the cycle after the R or B handshake; cpu_rdata is valid from that cycle and holds until the next read completes.
REQ-021 SHALL pulse cpu_err together with cpu_done when the captured RResp or BResp is not 2'b00; the transaction still completes.
REQ-022 SHALL not check M_RID, M_BID, or M_RLast.
REQ-023 SHALL never deassert a valid before its handshake, and SHALL not change M_*Addr or M_WData/M_WStrb while the corresponding valid is high.
REQ-024 SHALL assert M_RReady only in RD_DATA and M_BReady only in WR_RESP.

Reset
REQ-025 SHALL, on ARESETn=0 at any time including mid-transaction, immediately go to IDLE and set M_ARValid, M_AWValid, M_WValid, M_RReady, M_BReady, cpu_done, and cpu_err to 0, and cpu_rdata and the registered addr/data/strb to 0.
REQ-026 SHALL resume operation on the first rising edge after ARESETn returns to 1.

Verification
REQ-027 SHALL pass a read test: cpu_req, we=0, addr=0x0000_0010; ARReady=1 immediately; RValid=1 with RData=0xDEAD_BEEF two cycles later -> exactly one ARValid beat with ARAddr=0x10, cpu_done=1 one cycle after the R handshake, cpu_rdata=0xDEAD_BEEF, cpu_err=0.
REQ-028 SHALL pass a write test: we=1, addr=0x20, wdata=0x1234_5678, strb=4'b0011; WReady=1 on cycle 1, AWReady=1 on cycle 3 -> WValid drops after cycle 1 while AWValid holds to cycle 3; then BReady=1; one cycle after BValid, cpu_done=1.
REQ-029 SHALL pass a backpressure test: ARReady held low for 10 cycles -> ARValid and ARAddr stay stable and cpu_stall=1 for the whole wait.
REQ-030 SHALL pass an error test: BResp=2'b10 (SLVERR) -> cpu_done=1 and cpu_err=1 in the same single cycle; both are 0 the next cycle.
REQ-031 SHALL pass a reset test: ARESETn pulsed low while in RD_DATA -> all valids and readies go to 0 without waiting for a clock edge, state is IDLE, and a new cpu_req issued after reset completes normally.
